// File: rtl/z80fi_insn_monitor.sv
// Tracks one Z80 instruction from its first M1 fetch to retirement and emits a
// single-cycle z80fi packet with opcode bytes, register snapshots and M/T-cycle data.
module z80fi_insn_monitor #(
   parameter int REG_W  = 96,
   parameter int NUM_MC = 6,
   parameter int MCT_W  = 3
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      insn_start,
   input  logic                      fetch_valid,
   input  logic [7:0]                fetch_byte,
   input  logic                      mc_start,
   input  logic [MCT_W-1:0]          mc_type,
   input  logic                      t_tick,
   input  logic                      insn_done,
   input  logic [REG_W-1:0]          core_regs,
   output logic                      z80fi_valid,
   output logic [31:0]               z80fi_insn,
   output logic [2:0]                z80fi_insn_len,
   output logic [REG_W-1:0]          z80fi_regs_in,
   output logic [REG_W-1:0]          z80fi_regs_out,
   output logic [NUM_MC*MCT_W-1:0]   z80fi_mcycle_types,
   output logic [NUM_MC*4-1:0]       z80fi_tcycles,
   output logic                      z80fi_overflow
);

   localparam int IDX_W = (NUM_MC > 1) ? $clog2(NUM_MC) : 1;
   localparam logic [MCT_W-1:0] CYCLE_M1 = MCT_W'(1);

   typedef enum logic [0:0] {IDLE = 1'b0, COLLECT = 1'b1} state_t;

   typedef struct packed {
      logic [31:0]             bytes;
      logic [2:0]              len;
      logic [IDX_W-1:0]        idx;
      logic [NUM_MC*MCT_W-1:0] types;
      logic [NUM_MC*4-1:0]     tcnt;
      logic                    ovf;
   } col_t;

   // Applies one cycle of fetch / M-cycle / T-state events to a collect record.
   // A tick in the same cycle as an M-cycle start belongs to the new M-cycle.
   function automatic col_t apply_events(input col_t c, input logic fv, input logic [7:0] fb,
                                         input logic adv, input logic [MCT_W-1:0] mt,
                                         input logic tt);
      col_t r;
      r = c;
      if (fv) begin
         if (r.len == 3'd4) begin
            r.ovf = 1'b1;
         end else begin
            r.bytes[r.len*8 +: 8] = fb;
            r.len                 = r.len + 3'd1;
         end
      end
      if (adv) begin
         if (r.idx == IDX_W'(NUM_MC-1)) begin
            r.ovf = 1'b1;
         end else begin
            r.idx                         = r.idx + IDX_W'(1);
            r.types[r.idx*MCT_W +: MCT_W] = mt;
         end
      end
      if (tt) begin
         if (r.tcnt[r.idx*4 +: 4] == 4'd15) begin
            r.ovf = 1'b1;
         end else begin
            r.tcnt[r.idx*4 +: 4] = r.tcnt[r.idx*4 +: 4] + 4'd1;
         end
      end
      return r;
   endfunction

   state_t               state_r, next_state_s;
   col_t                 col_r, col_next_s, clear_s, fresh_s, cont_s;
   logic [REG_W-1:0]     regs_in_r;
   logic                 pkt_load_s;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_r <= IDLE;
      else          state_r <= next_state_s;
   end

   // Next-state logic: a new start always wins over retirement.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE:    next_state_s = insn_start ? COLLECT : IDLE;
         COLLECT: begin
            if (insn_start)     next_state_s = COLLECT;
            else if (insn_done) next_state_s = IDLE;
            else                next_state_s = COLLECT;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Candidate collect records: a fresh instruction or continuation of the current one.
   always_comb begin
      clear_s                  = '0;
      clear_s.types[MCT_W-1:0] = mc_start ? mc_type : CYCLE_M1;
      fresh_s = apply_events(clear_s, fetch_valid, fetch_byte, 1'b0, mc_type, t_tick);
      cont_s  = apply_events(col_r, fetch_valid, fetch_byte, mc_start, mc_type, t_tick);
   end

   // Output/control decode for the current state.
   always_comb begin
      pkt_load_s = 1'b0;
      col_next_s = col_r;
      case (state_r)
         IDLE: begin
            pkt_load_s = 1'b0;
            col_next_s = insn_start ? fresh_s : col_r;
         end
         COLLECT: begin
            pkt_load_s = insn_done;
            col_next_s = insn_start ? fresh_s : cont_s;
         end
         default: begin
            pkt_load_s = 1'b0;
            col_next_s = col_r;
         end
      endcase
   end

   // Collect buffers and entry register snapshot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_r     <= '0;
         regs_in_r <= '0;
      end else begin
         col_r <= col_next_s;
         if (insn_start) regs_in_r <= core_regs;
      end
   end

   // Packet registers; with a coincident start the old record is taken without this cycle's events.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         z80fi_valid        <= 1'b0;
         z80fi_insn         <= '0;
         z80fi_insn_len     <= '0;
         z80fi_regs_in      <= '0;
         z80fi_regs_out     <= '0;
         z80fi_mcycle_types <= '0;
         z80fi_tcycles      <= '0;
         z80fi_overflow     <= 1'b0;
      end else begin
         z80fi_valid <= pkt_load_s;
         if (pkt_load_s) begin
            z80fi_insn         <= insn_start ? col_r.bytes : cont_s.bytes;
            z80fi_insn_len     <= insn_start ? col_r.len   : cont_s.len;
            z80fi_mcycle_types <= insn_start ? col_r.types : cont_s.types;
            z80fi_tcycles      <= insn_start ? col_r.tcnt  : cont_s.tcnt;
            z80fi_overflow     <= insn_start ? col_r.ovf   : cont_s.ovf;
            z80fi_regs_in      <= regs_in_r;
            z80fi_regs_out     <= core_regs;
         end
      end
   end

endmodule

// File: tb/tb_z80fi_insn_monitor.sv
// Randomized scoreboard bench for z80fi_insn_monitor: instruction plans are turned into
// cycle events, expected packets come from a plan-level model, a monitor pops and compares.
module tb_z80fi_insn_monitor;
   localparam int REG_W = 96, NUM_MC = 6, MCT_W = 3;

   logic clk = 1'b0, reset_n = 1'b0;
   logic insn_start = 1'b0, fetch_valid = 1'b0, mc_start = 1'b0, t_tick = 1'b0, insn_done = 1'b0;
   logic [7:0] fetch_byte = 8'h00;
   logic [MCT_W-1:0] mc_type = '0;
   logic [REG_W-1:0] core_regs = '0;
   logic z80fi_valid, z80fi_overflow;
   logic [31:0] z80fi_insn;
   logic [2:0] z80fi_insn_len;
   logic [REG_W-1:0] z80fi_regs_in, z80fi_regs_out;
   logic [NUM_MC*MCT_W-1:0] z80fi_mcycle_types;
   logic [NUM_MC*4-1:0] z80fi_tcycles;

   z80fi_insn_monitor #(.REG_W(REG_W), .NUM_MC(NUM_MC), .MCT_W(MCT_W)) dut (
      .clk(clk), .reset_n(reset_n), .insn_start(insn_start), .fetch_valid(fetch_valid),
      .fetch_byte(fetch_byte), .mc_start(mc_start), .mc_type(mc_type), .t_tick(t_tick),
      .insn_done(insn_done), .core_regs(core_regs), .z80fi_valid(z80fi_valid),
      .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len), .z80fi_regs_in(z80fi_regs_in),
      .z80fi_regs_out(z80fi_regs_out), .z80fi_mcycle_types(z80fi_mcycle_types),
      .z80fi_tcycles(z80fi_tcycles), .z80fi_overflow(z80fi_overflow));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]             insn;
      logic [2:0]              len;
      logic [REG_W-1:0]        rin;
      logic [REG_W-1:0]        rout;
      logic [NUM_MC*MCT_W-1:0] types;
      logic [NUM_MC*4-1:0]     tc;
      logic                    ovf;
   } pkt_t;

   pkt_t exp_q[$];
   pkt_t last_pkt = '0;
   pkt_t mon_e;
   pkt_t held;
   bit   merge_pending = 1'b0;
   int   n_checks = 0, n_fail = 0;

   // instruction plan
   int         p_nb, p_nm, p_s0;
   logic [7:0] p_bytes[8];
   logic [2:0] p_mt[8];
   int         p_tk[8];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!reset_n) begin
         last_pkt = '0;
      end else if (z80fi_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 128'(z80fi_insn), 128'hFFFF_FFFF_FFFF);
         end else begin
            mon_e = exp_q.pop_front();
            chk("insn", 128'(z80fi_insn), 128'(mon_e.insn));
            chk("len", 128'(z80fi_insn_len), 128'(mon_e.len));
            chk("regs_in", 128'(z80fi_regs_in), 128'(mon_e.rin));
            chk("regs_out", 128'(z80fi_regs_out), 128'(mon_e.rout));
            chk("mcycle_types", 128'(z80fi_mcycle_types), 128'(mon_e.types));
            chk("tcycles", 128'(z80fi_tcycles), 128'(mon_e.tc));
            chk("overflow", 128'(z80fi_overflow), 128'(mon_e.ovf));
            last_pkt = mon_e;
         end
      end else begin
         chk("hold_small", 128'({z80fi_insn, z80fi_insn_len, z80fi_mcycle_types, z80fi_tcycles, z80fi_overflow}),
             128'({last_pkt.insn, last_pkt.len, last_pkt.types, last_pkt.tc, last_pkt.ovf}));
         chk("hold_regs", 128'(z80fi_regs_out ^ z80fi_regs_in), 128'(last_pkt.rout ^ last_pkt.rin));
      end
   end

   function automatic pkt_t model();
      pkt_t m;
      int   sum;
      m = '0;
      for (int i = 0; i < p_nb && i < 4; i++) m.insn[i*8 +: 8] = p_bytes[i];
      m.len = 3'((p_nb > 4) ? 4 : p_nb);
      m.ovf = (p_nb > 4) || (p_nm > NUM_MC);
      for (int k = 0; k < NUM_MC && k < p_nm; k++) begin
         m.types[k*MCT_W +: MCT_W] = (k == 0 && p_s0 == 0) ? 3'd1 : p_mt[k];
         sum = 0;
         if (k == NUM_MC-1) begin
            for (int j = k; j < p_nm; j++) sum += p_tk[j];
         end else begin
            sum = p_tk[k];
         end
         if (sum > 15) begin
            sum   = 15;
            m.ovf = 1'b1;
         end
         m.tc[k*4 +: 4] = 4'(sum);
      end
      return m;
   endfunction

   task automatic step();
      @(negedge clk);
      {insn_start, fetch_valid, mc_start, t_tick, insn_done} = 5'b0;
      core_regs  = {$urandom, $urandom, $urandom};
      fetch_byte = 8'($urandom);
      mc_type    = 3'($urandom);
   endtask

   // mode 0: done on last event cycle, 1: separate done cycle, 2: done with next start, 3: aborted
   task automatic run_insn(input int mode_in);
      logic       ev_ms[$];
      logic [2:0] ev_mt[$];
      logic       ev_tt[$];
      pkt_t       e;
      int         mode, len;
      mode = mode_in;
      for (int k = 0; k < p_nm; k++)
         for (int j = 0; j < ((p_tk[k] > 0) ? p_tk[k] : 1); j++) begin
            ev_ms.push_back(j == 0 && (k > 0 || p_s0 != 0));
            ev_mt.push_back(p_mt[k]);
            ev_tt.push_back(j < p_tk[k]);
         end
      while (ev_ms.size() < p_nb) begin
         ev_ms.push_back(1'b0); ev_mt.push_back(3'd0); ev_tt.push_back(1'b0);
      end
      len = ev_ms.size();
      if (mode == 0 && len < 2) mode = 1;
      e = model();
      for (int c = 0; c < len; c++) begin
         if (c == 0) begin
            insn_start = 1'b1;
            e.rin      = core_regs;
            if (merge_pending) begin
               insn_done     = 1'b1;
               held.rout     = core_regs;
               exp_q.push_back(held);
               merge_pending = 1'b0;
            end
         end
         mc_start = ev_ms[c];
         if (ev_ms[c]) mc_type = ev_mt[c];
         t_tick = ev_tt[c];
         if (c < p_nb) begin
            fetch_valid = 1'b1;
            fetch_byte  = p_bytes[c];
         end
         if (mode == 0 && c == len-1) begin
            insn_done = 1'b1;
            e.rout    = core_regs;
            exp_q.push_back(e);
         end
         step();
      end
      if (mode == 1) begin
         insn_done = 1'b1;
         e.rout    = core_regs;
         exp_q.push_back(e);
         step();
      end
      if (mode == 2) begin
         held          = e;
         merge_pending = 1'b1;
      end
   endtask

   task automatic plan(input int nb, input int nm, input int s0, input int tk_all);
      p_nb = nb; p_nm = nm; p_s0 = s0;
      for (int i = 0; i < 8; i++) begin
         p_bytes[i] = 8'($urandom);
         p_mt[i]    = 3'($urandom_range(1, 7));
         p_tk[i]    = tk_all;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
      step();
      if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 128'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int mode;
      step(); step();
      chk("reset_valid", 128'(z80fi_valid), 128'd0);
      chk("reset_outputs", 128'({z80fi_insn, z80fi_insn_len, z80fi_mcycle_types, z80fi_tcycles, z80fi_overflow}), 128'd0);
      reset_n = 1'b1;
      // done with no start since reset: ignored
      insn_done = 1'b1; step(); step(); step();

      // INC B
      plan(1, 1, 1, 4); p_bytes[0] = 8'h04; p_mt[0] = 3'd1;
      run_insn(0); step(); step();
      // back-to-back DEC A then INC C
      plan(1, 1, 0, 4); p_bytes[0] = 8'h3D; run_insn(2);
      plan(1, 1, 0, 4); p_bytes[0] = 8'h0C; run_insn(0); step();
      // five bytes, truncated
      plan(5, 2, 1, 3);
      p_bytes[0] = 8'hDD; p_bytes[1] = 8'hCB; p_bytes[2] = 8'h01; p_bytes[3] = 8'h06; p_bytes[4] = 8'hAA;
      run_insn(0); step();
      // seven M-cycles, then 16 ticks in one M-cycle
      plan(2, 7, 1, 1); run_insn(1);
      plan(1, 1, 0, 16); run_insn(0);
      // abort: only the second is reported
      plan(3, 3, 1, 2); run_insn(3); step();
      plan(2, 2, 0, 3); run_insn(0); step();
      drain();

      for (int n = 0; n < 150; n++) begin
         plan($urandom_range(0, 6), $urandom_range(1, 8), $urandom_range(0, 1), 0);
         for (int k = 0; k < 8; k++)
            p_tk[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 18) : $urandom_range(0, 5);
         mode = (n == 149) ? 0 : $urandom_range(0, 3);
         run_insn(mode);
         if (mode != 2) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
               if (mode != 3 && $urandom_range(0, 1) == 1) insn_done = 1'b1;
               step();
            end
         end
      end
      drain();

      // reset in the middle of an instruction, then a done: no packet, outputs cleared
      plan(2, 2, 1, 3); p_nb = 2;
      insn_start = 1'b1; fetch_valid = 1'b1; step();
      t_tick = 1'b1; step();
      reset_n = 1'b0; step(); step();
      chk("midreset_outputs", 128'({z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_mcycle_types, z80fi_tcycles, z80fi_overflow}), 128'd0);
      chk("midreset_regs", 128'(z80fi_regs_in | z80fi_regs_out), 128'd0);
      reset_n = 1'b1; t_tick = 1'b1; step();
      insn_done = 1'b1; step(); step(); step();
      chk("post_reset_valid", 128'(z80fi_valid), 128'd0);
      chk("post_reset_insn", 128'(z80fi_insn), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
